// File: rtl/decode_pkg.sv
// Shared types for the decode stage: op-class enum, base opcode constants,
// instruction-format helper and the decoded-bundle struct.
package decode_pkg;

    // Op class reported with every decoded bundle.
    typedef enum logic [3:0] {
        OpNone   = 4'd0,
        OpReg    = 4'd1,
        OpImm    = 4'd2,
        OpLoad   = 4'd3,
        OpStore  = 4'd4,
        OpBranch = 4'd5,
        OpJal    = 4'd6,
        OpJalr   = 4'd7,
        OpLui    = 4'd8,
        OpAuipc  = 4'd9
    } op_class_e;

    // Instruction encoding format, derived from the op class.
    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtR    = 3'd1,
        FmtI    = 3'd2,
        FmtS    = 3'd3,
        FmtB    = 3'd4,
        FmtU    = 3'd5,
        FmtJ    = 3'd6
    } inst_fmt_e;

    localparam logic [6:0] OpcodeOp     = 7'b0110011;
    localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
    localparam logic [6:0] OpcodeLoad   = 7'b0000011;
    localparam logic [6:0] OpcodeStore  = 7'b0100011;
    localparam logic [6:0] OpcodeBranch = 7'b1100011;
    localparam logic [6:0] OpcodeJal    = 7'b1101111;
    localparam logic [6:0] OpcodeJalr   = 7'b1100111;
    localparam logic [6:0] OpcodeLui    = 7'b0110111;
    localparam logic [6:0] OpcodeAuipc  = 7'b0010111;

    // Fixed-width part of a decoded bundle. The XLEN-wide pc and immediate
    // travel beside it because a package cannot be parameterised.
    typedef struct packed {
        op_class_e   op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        illegal;
    } decode_bundle_t;

    // Map an op class onto the format that governs its fields.
    function automatic inst_fmt_e op_format(input op_class_e op);
        inst_fmt_e fmt;
        case (op)
            OpReg:                  fmt = FmtR;
            OpImm, OpLoad, OpJalr:  fmt = FmtI;
            OpStore:                fmt = FmtS;
            OpBranch:               fmt = FmtB;
            OpLui, OpAuipc:         fmt = FmtU;
            OpJal:                  fmt = FmtJ;
            default:                fmt = FmtNone;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: 32-bit instruction in, decoded
// bundle plus XLEN-wide immediate out.
// Optional reserved-encoding detection is built when DECODE_ILLEGAL_EN is
// defined; otherwise the illegal flag is a constant 0.
module decode_comb
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    output decode_bundle_t  bundle,
    output logic [XLEN-1:0] imm
);

    logic [6:0]         opcode;
    logic [2:0]         funct3_raw;
    logic [6:0]         funct7_raw;
    op_class_e          op;
    inst_fmt_e          fmt;
    logic               use_rs1;
    logic               use_rs2;
    logic               use_rd;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [20:0] imm_j;
    logic signed [31:0] imm_u;
    logic               illegal;

    assign opcode     = inst[6:0];
    assign funct3_raw = inst[14:12];
    assign funct7_raw = inst[31:25];

    // Classify the full 7-bit opcode into an op class.
    always_comb begin
        op = OpNone;
        case (opcode)
            OpcodeOp:     op = OpReg;
            OpcodeOpImm:  op = OpImm;
            OpcodeLoad:   op = OpLoad;
            OpcodeStore:  op = OpStore;
            OpcodeBranch: op = OpBranch;
            OpcodeJal:    op = OpJal;
            OpcodeJalr:   op = OpJalr;
            OpcodeLui:    op = OpLui;
            OpcodeAuipc:  op = OpAuipc;
            default:      op = OpNone;
        endcase
    end

    assign fmt     = op_format(op);
    assign use_rs1 = fmt inside {FmtR, FmtI, FmtS, FmtB};
    assign use_rs2 = fmt inside {FmtR, FmtS, FmtB};
    assign use_rd  = fmt inside {FmtR, FmtI, FmtJ, FmtU};

    // Assemble every immediate shape, then sign-extend the one for this format.
    always_comb begin
        imm_i = inst[31:20];
        imm_s = {inst[31:25], inst[11:7]};
        imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_u = {inst[31:12], 12'b0};
        case (fmt)
            FmtI:    imm = XLEN'(imm_i);
            FmtS:    imm = XLEN'(imm_s);
            FmtB:    imm = XLEN'(imm_b);
            FmtJ:    imm = XLEN'(imm_j);
            FmtU:    imm = XLEN'(imm_u);
            default: imm = '0;
        endcase
    end

    // Register specifiers, write enable and function codes of the bundle.
    always_comb begin
        bundle        = '0;
        bundle.op     = op;
        bundle.rs1    = use_rs1 ? inst[19:15] : 5'd0;
        bundle.rs2    = use_rs2 ? inst[24:20] : 5'd0;
        bundle.rd     = use_rd  ? inst[11:7]  : 5'd0;
        bundle.rd_we  = use_rd && (inst[11:7] != 5'd0);
        bundle.funct3 = (use_rs1) ? funct3_raw : 3'd0;
        // funct7 only carries meaning for register ops and immediate shifts.
        if ((op == OpReg) ||
            ((op == OpImm) && ((funct3_raw == 3'b001) || (funct3_raw == 3'b101)))) begin
            bundle.funct7 = funct7_raw;
        end
        bundle.illegal = illegal;
    end

`ifdef DECODE_ILLEGAL_EN
    // Flag unknown opcodes, compressed encodings and reserved funct fields.
    always_comb begin
        illegal = 1'b0;
        case (op)
            OpNone: illegal = 1'b1;
            OpReg: begin
                illegal = !((funct7_raw == 7'h00) ||
                            ((funct7_raw == 7'h20) &&
                             ((funct3_raw == 3'b000) || (funct3_raw == 3'b101))));
            end
            OpImm: begin
                // RV64 shift amounts spill into funct7[0].
                if (funct3_raw == 3'b001) begin
                    illegal = (funct7_raw[6:1] != 6'd0) || ((XLEN == 32) && funct7_raw[0]);
                end else if (funct3_raw == 3'b101) begin
                    illegal = ({funct7_raw[6], funct7_raw[4:1]} != 5'd0) ||
                              ((XLEN == 32) && funct7_raw[0]);
                end
            end
            OpLoad: begin
                illegal = (funct3_raw == 3'b111) ||
                          ((XLEN == 32) && ((funct3_raw == 3'b011) || (funct3_raw == 3'b110)));
            end
            OpStore:  illegal = funct3_raw[2] || ((XLEN == 32) && (funct3_raw == 3'b011));
            OpBranch: illegal = (funct3_raw == 3'b010) || (funct3_raw == 3'b011);
            OpJalr:   illegal = (funct3_raw != 3'b000);
            default:  illegal = 1'b0;
        endcase
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes the incoming instruction combinationally and buffers
// {pc, imm, fields} in a DEPTH-entry FIFO with valid/ready on both sides.
// Build option: DECODE_ILLEGAL_EN enables reserved-encoding detection in
// decode_comb; without it out_illegal is constant 0.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,  // 32 or 64
    parameter int unsigned DEPTH = 2    // power of two, >= 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output op_class_e       out_op,
    output logic            out_illegal
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    decode_bundle_t  dec_bundle;
    logic [XLEN-1:0] dec_imm;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    logic [XLEN-1:0] pc_mem_q     [DEPTH];
    logic [XLEN-1:0] imm_mem_q    [DEPTH];
    decode_bundle_t  fields_mem_q [DEPTH];
    decode_bundle_t  head;

    decode_comb #(
        .XLEN (XLEN)
    ) u_decode_comb (
        .inst   (in_inst),
        .bundle (dec_bundle),
        .imm    (dec_imm)
    );

    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    // A flushed cycle must not leave its input behind in the buffer.
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    // Next pointer and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; cleared on reset so every output field reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]     <= '0;
                imm_mem_q[i]    <= '0;
                fields_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]     <= in_pc;
            imm_mem_q[wr_ptr_q]    <= dec_imm;
            fields_mem_q[wr_ptr_q] <= dec_bundle;
        end
    end

    // Present the head entry; it stays put until popped.
    always_comb begin
        head        = fields_mem_q[rd_ptr_q];
        out_pc      = pc_mem_q[rd_ptr_q];
        out_imm     = imm_mem_q[rd_ptr_q];
        out_rs1     = head.rs1;
        out_rs2     = head.rs2;
        out_rd      = head.rd;
        out_rd_we   = head.rd_we;
        out_funct3  = head.funct3;
        out_funct7  = head.funct7;
        out_op      = head.op;
        out_illegal = head.illegal;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: an XLEN=32 and an XLEN=64 instance
// share one stimulus stream and are checked against a queue-based model.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;

    logic        r32_in_ready, r32_out_valid, r32_rd_we, r32_illegal;
    logic [31:0] r32_pc, r32_imm;
    logic [4:0]  r32_rs1, r32_rs2, r32_rd;
    logic [2:0]  r32_funct3;
    logic [6:0]  r32_funct7;
    op_class_e   r32_op;

    logic        r64_in_ready, r64_out_valid, r64_rd_we, r64_illegal;
    logic [63:0] r64_pc, r64_imm;
    logic [4:0]  r64_rs1, r64_rs2, r64_rd;
    logic [2:0]  r64_funct3;
    logic [6:0]  r64_funct7;
    op_class_e   r64_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r32_in_ready), .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(r32_out_valid), .out_ready(out_ready), .out_pc(r32_pc),
        .out_rs1(r32_rs1), .out_rs2(r32_rs2), .out_rd(r32_rd), .out_rd_we(r32_rd_we),
        .out_imm(r32_imm), .out_funct3(r32_funct3), .out_funct7(r32_funct7),
        .out_op(r32_op), .out_illegal(r32_illegal)
    );

    decode_stage #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r64_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(r64_out_valid), .out_ready(out_ready), .out_pc(r64_pc),
        .out_rs1(r64_rs1), .out_rs2(r64_rs2), .out_rd(r64_rd), .out_rd_we(r64_rd_we),
        .out_imm(r64_imm), .out_funct3(r64_funct3), .out_funct7(r64_funct7),
        .out_op(r64_op), .out_illegal(r64_illegal)
    );

    typedef enum {FR, FI, FS, FB, FU, FJ, FN} fmt_e;

    typedef struct {
        op_class_e   op;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_we;
        logic [63:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        illegal;
        logic [63:0] pc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reserved-encoding rules for RV32I.
    function automatic logic illegal32(input logic [31:0] inst, input op_class_e op);
        int f3 = int'(inst[14:12]);
        int f7 = int'(inst[31:25]);
        if (inst[1:0] != 2'b11) return 1'b1;
        case (op)
            OpNone:   return 1'b1;
            OpReg:    return !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
            OpImm:    return (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
            OpLoad:   return f3 == 3 || f3 == 6 || f3 == 7;
            OpStore:  return f3 > 2;
            OpBranch: return f3 == 2 || f3 == 3;
            OpJalr:   return f3 != 0;
            default:  return 1'b0;
        endcase
    endfunction

    // Reference decode using integer arithmetic for the immediates.
    function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc);
        exp_t   e;
        fmt_e   fmt = FN;
        longint v = 0;
        e.pc = pc;
        e.op = OpNone;
        case (inst[6:0])
            7'h33: begin e.op = OpReg;    fmt = FR; end
            7'h13: begin e.op = OpImm;    fmt = FI; end
            7'h03: begin e.op = OpLoad;   fmt = FI; end
            7'h23: begin e.op = OpStore;  fmt = FS; end
            7'h63: begin e.op = OpBranch; fmt = FB; end
            7'h6F: begin e.op = OpJal;    fmt = FJ; end
            7'h67: begin e.op = OpJalr;   fmt = FI; end
            7'h37: begin e.op = OpLui;    fmt = FU; end
            7'h17: begin e.op = OpAuipc;  fmt = FU; end
            default: ;
        endcase
        case (fmt)
            FI: v = longint'(inst[31:20]) - (inst[31] ? 64'sd4096 : 64'sd0);
            FS: v = longint'({inst[31:25], inst[11:7]}) - (inst[31] ? 64'sd4096 : 64'sd0);
            FB: v = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32 +
                    longint'(inst[11:8]) * 2 - (inst[31] ? 64'sd4096 : 64'sd0);
            FJ: v = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048 +
                    longint'(inst[30:21]) * 2 - (inst[31] ? 64'sd1048576 : 64'sd0);
            FU: v = longint'(inst[31:12]) * 4096 - (inst[31] ? 64'sd4294967296 : 64'sd0);
            default: v = 0;
        endcase
        e.imm   = v;
        e.rs1   = (fmt inside {FR, FI, FS, FB}) ? inst[19:15] : 5'd0;
        e.rs2   = (fmt inside {FR, FS, FB}) ? inst[24:20] : 5'd0;
        e.rd    = (fmt inside {FR, FI, FU, FJ}) ? inst[11:7] : 5'd0;
        e.rd_we = (e.rd != 0);
        e.f3    = (fmt inside {FR, FI, FS, FB}) ? inst[14:12] : 3'd0;
        e.f7    = (e.op == OpReg || (e.op == OpImm && (inst[14:12] == 1 || inst[14:12] == 5)))
                  ? inst[31:25] : 7'd0;
`ifdef DECODE_ILLEGAL_EN
        e.illegal = illegal32(inst, e.op);
`else
        e.illegal = 1'b0;
`endif
        return e;
    endfunction

    // Model of the buffer: push when not full (pre-pop size), pop when non-empty.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            automatic bit do_push = in_valid && (q.size() < DEPTH);
            automatic bit do_pop  = (q.size() > 0) && out_ready;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model(in_inst, in_pc));
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready32", 64'(r32_in_ready), 64'(q.size() < DEPTH));
        chk("in_ready64", 64'(r64_in_ready), 64'(q.size() < DEPTH));
        chk("out_valid32", 64'(r32_out_valid), 64'(q.size() > 0));
        chk("out_valid64", 64'(r64_out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("pc32", 64'(r32_pc), {32'b0, q[0].pc[31:0]});
            chk("pc64", r64_pc, q[0].pc);
            chk("imm32", 64'(r32_imm), {32'b0, q[0].imm[31:0]});
            chk("imm64", r64_imm, q[0].imm);
            chk("op32", 64'(r32_op), 64'(q[0].op));
            chk("op64", 64'(r64_op), 64'(q[0].op));
            chk("rs1", 64'(r32_rs1), 64'(q[0].rs1));
            chk("rs2", 64'(r32_rs2), 64'(q[0].rs2));
            chk("rd", 64'(r32_rd), 64'(q[0].rd));
            chk("rd_we", 64'(r32_rd_we), 64'(q[0].rd_we));
            chk("funct3", 64'(r32_funct3), 64'(q[0].f3));
            chk("funct7", 64'(r32_funct7), 64'(q[0].f7));
            chk("illegal", 64'(r32_illegal), 64'(q[0].illegal));
            chk("rd64", 64'(r64_rd), 64'(q[0].rd));
        end
    end

    // Single push into a non-full buffer; returns just after the accepting edge.
    task automatic push_one(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] stream [12] = '{
        32'h80000537, 32'h00001017, 32'hFE208CE3, 32'hFFC22183,
        32'h000280E7, 32'h4033D313, 32'h01F49413, 32'h0FF0F093,
        32'h0020A063, 32'hDEADBEEF, 32'h0000000B, 32'h12345678
    };

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(r32_in_ready), 64'd1);
        chk("rst_out_valid", 64'(r32_out_valid), 64'd0);
        chk("rst_pc", 64'(r32_pc), 64'd0);
        chk("rst_imm64", r64_imm, 64'd0);
        chk("rst_rd_we", 64'(r32_rd_we), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi x1,x2,-1
        push_one(32'hFFF10093, 64'h1000);
        @(negedge clk);
        chk("addi_valid", 64'(r32_out_valid), 64'd1);
        chk("addi_op", 64'(r32_op), 64'(OpImm));
        chk("addi_rs1", 64'(r32_rs1), 64'd2);
        chk("addi_rs2", 64'(r32_rs2), 64'd0);
        chk("addi_rd", 64'(r32_rd), 64'd1);
        chk("addi_rd_we", 64'(r32_rd_we), 64'd1);
        chk("addi_imm32", 64'(r32_imm), 64'hFFFFFFFF);
        @(posedge clk);
        #1;

        // sw x5,8(x6)
        push_one(32'h00532423, 64'h1004);
        @(negedge clk);
        chk("sw_op", 64'(r32_op), 64'(OpStore));
        chk("sw_rs1", 64'(r32_rs1), 64'd6);
        chk("sw_rs2", 64'(r32_rs2), 64'd5);
        chk("sw_rd", 64'(r32_rd), 64'd0);
        chk("sw_rd_we", 64'(r32_rd_we), 64'd0);
        chk("sw_imm", 64'(r32_imm), 64'd8);
        chk("sw_funct3", 64'(r32_funct3), 64'd2);
        @(posedge clk);
        #1;

        // jal x1,-4
        push_one(32'hFFDFF0EF, 64'hFFFF_0000_0000_1008);
        @(negedge clk);
        chk("jal_op", 64'(r64_op), 64'(OpJal));
        chk("jal_rd", 64'(r64_rd), 64'd1);
        chk("jal_imm64", r64_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("jal_pc64", r64_pc, 64'hFFFF_0000_0000_1008);
        chk("jal_imm32", 64'(r32_imm), 64'hFFFFFFFC);
        @(posedge clk);
        #1;

        // Back-pressure: sub, add buffered, third push blocked.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h402081B3; in_pc = 64'h2000;
        @(posedge clk); #1;
        in_inst   = 32'h007302B3; in_pc = 64'h2004;
        @(posedge clk); #1;
        in_inst   = 32'h00100093; in_pc = 64'h2008;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(r32_in_ready), 64'd0);
            chk("bp_pc", 64'(r32_pc), 64'h2000);
            chk("bp_funct7", 64'(r32_funct7), 64'h20);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head0", 64'(r32_pc), 64'h2000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_head1", 64'(r32_pc), 64'h2004);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_head2", 64'(r32_pc), 64'h2008);
        @(posedge clk); #1;

        // Flush with two buffered and a concurrent push.
        out_ready = 1'b0;
        push_one(32'h00100093, 64'h3000);
        push_one(32'h00200113, 64'h3004);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00300193; in_pc = 64'h3008;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", 64'(r32_out_valid), 64'd0);
        chk("flush_ready", 64'(r32_in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        // All-zero word.
        push_one(32'h00000000, 64'h4000);
        @(negedge clk);
        chk("zero_op", 64'(r32_op), 64'(OpNone));
        chk("zero_imm", 64'(r32_imm), 64'd0);
`ifdef DECODE_ILLEGAL_EN
        chk("zero_illegal", 64'(r32_illegal), 64'd1);
`else
        chk("zero_illegal", 64'(r32_illegal), 64'd0);
`endif
        @(posedge clk); #1;

        // lui x10,0x80000 pins the U-immediate sign extension.
        push_one(32'h80000537, 64'h4004);
        @(negedge clk);
        chk("lui_imm64", r64_imm, 64'hFFFFFFFF80000000);
        chk("lui_imm32", 64'(r32_imm), 64'h80000000);
        @(posedge clk); #1;

        // Directed stream under a fixed out_ready pattern.
        for (int i = 0; i < 12; i++) begin
            automatic int  budget = 20;
            automatic bit  taken  = 1'b0;
            in_valid = 1'b1;
            in_inst  = stream[i];
            in_pc    = 64'h5000 + 64'(4 * i);
            while (!taken && budget > 0) begin
                out_ready = ((i + budget) % 3) != 1;
                @(negedge clk);
                taken = r32_in_ready;
                @(posedge clk); #1;
                budget--;
            end
            if (!taken) chk("stream_accept_timeout", 64'd0, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Reset asserted mid-operation with entries buffered.
        out_ready = 1'b0;
        push_one(32'h00100093, 64'h6000);
        push_one(32'h00200113, 64'h6004);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(r32_out_valid), 64'd0);
        chk("mrst_ready", 64'(r32_in_ready), 64'd1);
        chk("mrst_pc", 64'(r32_pc), 64'd0);
        chk("mrst_imm64", r64_imm, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1, discards all buffered and in-flight bundles.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_inst input 32, in_pc input XLEN; in_pc is the fetch address of in_inst.
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1.
REQ-008 SHALL have output fields out_pc XLEN, out_rs1 5, out_rs2 5, out_rd 5, out_rd_we 1, out_imm XLEN, out_funct3 3, out_funct7 7, out_op (package op-class enum), out_illegal 1.

Function
REQ-009 SHALL decode in_inst combinationally and push {pc, fields} into a DEPTH-entry FIFO when in_valid && in_ready.
REQ-010 SHALL drive in_ready = !full; no push occurs while full, even if the same cycle pops.
REQ-011 SHALL present a bundle on out_valid on the cycle after its push, never in the push cycle (latency 1).
REQ-012 SHALL pop on out_valid && out_ready; outputs hold stable while out_valid && !out_ready.
REQ-013 SHALL handle a push and a pop in the same cycle when not full or empty, leaving occupancy unchanged; pointers wrap modulo DEPTH.
REQ-014 SHALL classify by opcode into OP_REG, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, else NONE.
REQ-015 SHALL zero rs1, rs2 and rd when the format has no such field: R/I/S/B use rs1; R/S/B use rs2; R/I/J/U use rd.
REQ-016 SHALL set out_rd_we = 1 only when the format writes rd and rd != 0.
REQ-017 SHALL sign-extend I/S/B/J immediates from bit 31 to XLEN, and sign-extend U-immediate {inst[31:12],12'b0} to XLEN; imm = 0 for R and NONE.
REQ-018 SHALL drive funct7 = inst[31:25] for OP_REG and OP_IMM shifts (funct3 001/101); otherwise 0.
REQ-019 SHALL, on flush, empty the FIFO at the next edge and drop any push in the same cycle; out_valid = 0 the following cycle.

Reset
REQ-020 SHALL, on rst_n low, asynchronously clear pointers and count; out_valid = 0 and in_ready = 1 from reset assertion until the first push after release.
REQ-021 SHALL reset payload storage to zero so all out_* fields read 0 after reset.
REQ-022 SHALL discard buffered contents on reset asserted mid-operation, with no partial pops.

Configuration
REQ-023 SHALL honour macro DECODE_ILLEGAL_EN.
REQ-024 With DECODE_ILLEGAL_EN: out_illegal = 1 when op = NONE, inst[1:0] != 2'b11, or funct3/funct7 is reserved for the class; the bundle is still delivered.
REQ-025 Without DECODE_ILLEGAL_EN: out_illegal tied to 0; no checking logic is present.

Structure
REQ-026 SHALL place the op-class enum, the opcode constants and the decoded-bundle packed struct in package decode_pkg.
REQ-027 SHALL split into a combinational sub-module decode_comb (inst -> bundle) and a FIFO/handshake wrapper in decode_stage.

Verification
REQ-028 addi x1,x2,-1 (0xFFF10093), XLEN=32 -> next cycle: op=OP_IMM, rs1=2, rs2=0, rd=1, rd_we=1, imm=0xFFFFFFFF.
REQ-029 sw x5,8(x6) (0x00532423) -> op=STORE, rs1=6, rs2=5, rd=0, rd_we=0, imm=8, funct3=2.
REQ-030 jal x1,-4 (0xFFDFF0EF), XLEN=64 -> op=JAL, rd=1, imm=0xFFFFFFFFFFFFFFFC.
REQ-031 sub x3,x1,x2 (0x402081B3) -> op=OP_REG, funct7=0x20; hold out_ready=0 with DEPTH=2: third push blocked (in_ready=0), bundle stable; release pops in order.
REQ-032 Two bundles buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, in_ready=1; flushed input never appears.
REQ-033 in_inst=0x00000000 -> out_illegal=1, op=NONE with DECODE_ILLEGAL_EN; out_illegal=0 without.
